// File: rtl/pic_inta_sequencer.sv
// INT/INTA handshake sequencer: drives the CPU INT line, runs the two-pulse INTA cycle,
// places the vector byte on the bus and maintains the in-service register with nonspecific EOI.
module pic_inta_sequencer #(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic [2:0] isr_level,
    input  logic       special_delivery,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       aeoi_mode,
    input  logic       eoi_cmd,
    output logic       int_out,
    output logic [1:0] int_a_counter,
    output logic       eoi_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] in_service
);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   settle_q;
    logic [2:0]             level_q;
    logic                   spec_q;
    logic                   sync;
    logic                   settled;
    logic                   fall;
    logic                   rise;
    logic                   eoi_fire;
    logic [7:0]             low_bit;
    logic [7:0]             set_mask;

    // Edges are qualified until the chain holds real pin samples, so a pin
    // already low when reset releases is never mistaken for a fresh fall.
    assign sync     = sync_q[SYNC_STAGES-1];
    assign settled  = settle_q[SYNC_STAGES];
    assign fall     = settled & hist_q & ~sync;
    assign rise     = settled & ~hist_q & sync;
    assign eoi_fire = eoi_cmd & ~aeoi_mode;
    assign low_bit  = in_service & (~in_service + 8'd1);

    always_comb begin
        set_mask = 8'h00;
        if (state == GAP && fall && !aeoi_mode && !spec_q)
            set_mask = 8'd1 << level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            hist_q   <= 1'b1;
            settle_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], inta_n};
            hist_q   <= sync;
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            int_out       <= 1'b0;
            int_a_counter <= 2'b00;
            data_out      <= 8'h00;
            data_oe       <= 1'b0;
            level_q       <= 3'd0;
            spec_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    int_a_counter <= 2'b00;
                    if (int_req) begin
                        state   <= REQ;
                        int_out <= 1'b1;
                    end
                end
                REQ: begin
                    if (fall) begin
                        state         <= ACK1;
                        int_a_counter <= 2'b01;
                        int_out       <= 1'b0;
                    end
                end
                ACK1: begin
                    level_q <= special_delivery ? SPURIOUS_LEVEL : isr_level;
                    spec_q  <= special_delivery;
                    if (rise) state <= GAP;
                end
                GAP: begin
                    if (fall) begin
                        state         <= ACK2;
                        int_a_counter <= 2'b10;
                        data_out      <= {vector_base, level_q};
                        data_oe       <= 1'b1;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state         <= IDLE;
                        data_oe       <= 1'b0;
                        int_a_counter <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear works on the pre-set value; OR-ing the set last lets it win on a shared bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_service <= 8'h00;
            eoi_out    <= 1'b0;
        end else begin
            in_service <= (in_service & ~(eoi_fire ? low_bit : 8'h00)) | set_mask;
            eoi_out    <= eoi_fire;
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: handshakes, AEOI, nested EOI, spurious,
// coincident set/clear and reset in the middle of a handshake.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_req = 1'b0;
    logic [2:0] isr_level = 3'd0;
    logic       special_delivery = 1'b0;
    logic       inta_n = 1'b1;
    logic [4:0] vector_base = 5'b01000;
    logic       aeoi_mode = 1'b0;
    logic       eoi_cmd = 1'b0;
    logic       int_out;
    logic [1:0] int_a_counter;
    logic       eoi_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] in_service;

    int n_cmp = 0;
    int n_bad = 0;

    pic_inta_sequencer #(.SYNC_STAGES(2), .SPURIOUS_LEVEL(3'd7)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .int_req          (int_req),
        .isr_level        (isr_level),
        .special_delivery (special_delivery),
        .inta_n           (inta_n),
        .vector_base      (vector_base),
        .aeoi_mode        (aeoi_mode),
        .eoi_cmd          (eoi_cmd),
        .int_out          (int_out),
        .int_a_counter    (int_a_counter),
        .eoi_out          (eoi_out),
        .data_out         (data_out),
        .data_oe          (data_oe),
        .in_service       (in_service)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full two-pulse handshake; each INTA low and high phase lasts 4 clocks.
    task automatic handshake(input logic [7:0] exp_vec, input logic [7:0] exp_isr,
                             input logic drop_req, input logic spec, input logic eoi_at_ack2);
        int_req = 1'b1;
        tick(1);
        check("req_int_out", 8'(int_out), 8'h01);
        if (drop_req) begin
            int_req = 1'b0;
            tick(1);
            check("req_held_int_out", 8'(int_out), 8'h01);
        end
        inta_n = 1'b0;
        tick(2);
        check("pre_ack1_cnt", 8'(int_a_counter), 8'h00);
        check("pre_ack1_int_out", 8'(int_out), 8'h01);
        tick(1);
        check("ack1_cnt", 8'(int_a_counter), 8'h01);
        check("ack1_int_out", 8'(int_out), 8'h00);
        special_delivery = spec;
        int_req = 1'b0;
        tick(1);
        inta_n = 1'b1;
        tick(3);
        special_delivery = 1'b0;
        check("gap_cnt", 8'(int_a_counter), 8'h01);
        check("gap_oe", 8'(data_oe), 8'h00);
        tick(1);
        inta_n = 1'b0;
        tick(2);
        check("pre_ack2_oe", 8'(data_oe), 8'h00);
        eoi_cmd = eoi_at_ack2;
        tick(1);
        eoi_cmd = 1'b0;
        check("ack2_cnt", 8'(int_a_counter), 8'h02);
        check("ack2_oe", 8'(data_oe), 8'h01);
        check("ack2_vec", data_out, exp_vec);
        check("ack2_isr", in_service, exp_isr);
        tick(1);
        inta_n = 1'b1;
        tick(2);
        check("ack2_hold_oe", 8'(data_oe), 8'h01);
        tick(1);
        check("end_cnt", 8'(int_a_counter), 8'h00);
        check("end_oe", 8'(data_oe), 8'h00);
        check("end_vec_kept", data_out, exp_vec);
        tick(2);
    endtask

    task automatic eoi(input logic [7:0] exp_isr, input logic exp_pulse);
        eoi_cmd = 1'b1;
        tick(1);
        eoi_cmd = 1'b0;
        check("eoi_isr", in_service, exp_isr);
        check("eoi_pulse", 8'(eoi_out), 8'(exp_pulse));
        tick(1);
        check("eoi_pulse_end", 8'(eoi_out), 8'h00);
    endtask

    initial begin
        tick(2);
        check("rst_int_out", 8'(int_out), 8'h00);
        check("rst_cnt", 8'(int_a_counter), 8'h00);
        check("rst_eoi", 8'(eoi_out), 8'h00);
        check("rst_data", data_out, 8'h00);
        check("rst_oe", 8'(data_oe), 8'h00);
        check("rst_isr", in_service, 8'h00);
        rst_n = 1'b1;
        tick(5);

        // Normal handshake at level 3, then release it with EOI
        isr_level = 3'd3;
        handshake(8'h43, 8'h08, 1'b0, 1'b0, 1'b0);
        eoi(8'h00, 1'b1);

        // AEOI: vector delivered, nothing latched, EOI suppressed
        aeoi_mode = 1'b1;
        handshake(8'h43, 8'h00, 1'b0, 1'b0, 1'b0);
        eoi(8'h00, 1'b0);
        aeoi_mode = 1'b0;

        // Nested service 5 then 2, released lowest index first
        isr_level = 3'd5;
        handshake(8'h45, 8'h20, 1'b0, 1'b0, 1'b0);
        isr_level = 3'd2;
        handshake(8'h42, 8'h24, 1'b0, 1'b0, 1'b0);
        eoi(8'h20, 1'b1);
        eoi(8'h00, 1'b1);
        eoi(8'h00, 1'b1);

        // Spurious: request withdrawn during REQ
        isr_level = 3'd3;
        handshake(8'h47, 8'h00, 1'b1, 1'b1, 1'b0);

        // Coincident EOI clear and ACK2 set
        isr_level = 3'd0;
        handshake(8'h40, 8'h01, 1'b0, 1'b0, 1'b0);
        isr_level = 3'd4;
        handshake(8'h44, 8'h10, 1'b0, 1'b0, 1'b1);
        eoi(8'h00, 1'b1);

        // Reset while in ACK2 with INTA still low
        isr_level = 3'd6;
        int_req = 1'b1;
        tick(1);
        inta_n = 1'b0;
        tick(4);
        int_req = 1'b0;
        inta_n = 1'b1;
        tick(4);
        inta_n = 1'b0;
        tick(3);
        check("mid_ack2_oe", 8'(data_oe), 8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", 8'(data_oe), 8'h00);
        check("mid_rst_cnt", 8'(int_a_counter), 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_idle_int", 8'(int_out), 8'h00);
        check("post_rst_idle_cnt", 8'(int_a_counter), 8'h00);
        int_req = 1'b1;
        tick(6);
        check("post_rst_no_fall_cnt", 8'(int_a_counter), 8'h00);
        check("post_rst_no_fall_int", 8'(int_out), 8'h01);
        inta_n = 1'b1;
        tick(4);
        isr_level = 3'd1;
        handshake(8'h41, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
